// File: rtl/cdc_xfer_pkg.sv
// Shared state encoding and default sizing for the CDC transfer arbiter.
// The ERR encoding is reserved in every build but is only reachable with the watchdog enabled.
package cdc_xfer_pkg;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_TIMEOUT_CYC = 255;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t REQ_HI = 2'd1;
    localparam state_t REQ_LO = 2'd2;
    localparam state_t ERR    = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester strictly after 'last', wrapping modulo NUM_REQ.
// Purely combinational; the caller decides when the result is consumed.
module rr_arbiter
    import cdc_xfer_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int               pos;
    logic [IDX_W-1:0] idx;
    logic             found;

    // NOTE: every variable gets a default before the loop so no path leaves a latch behind.
    always_comb begin
        gnt   = '0;
        pos   = 0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = int'(last) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = IDX_W'(pos);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/cdc_xfer_arbiter.sv
// Shares one 4-phase CDC request/ack channel among NUM_REQ source requesters, round-robin.
// Define CDC_XFER_TIMEOUT_EN to add the per-phase watchdog, the ERR state and a live timeout_err.
module cdc_xfer_arbiter
    import cdc_xfer_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        src_req,
    input  logic [NUM_REQ*DATA_W-1:0] src_data,
    output logic [NUM_REQ-1:0]        src_gnt,
    output logic [NUM_REQ-1:0]        src_done,
    output logic                      req_out,
    output logic [DATA_W-1:0]         data_out,
    input  logic                      ack_sync,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             state;
    logic [IDX_W-1:0]   last_granted;
    logic [IDX_W-1:0]   cur_idx;
    logic [NUM_REQ-1:0] arb_gnt;
    logic               arb_valid;
    logic [IDX_W-1:0]   arb_idx;
    logic [DATA_W-1:0]  arb_data;
    logic               grant_now;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (src_req),
        .last  (last_granted),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    always_comb begin
        arb_idx  = '0;
        arb_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                arb_idx  = IDX_W'(i);
                arb_data = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A high ack while idle is a leftover from an aborted handshake; wait for it to clear.
    assign grant_now = (state == IDLE) && arb_valid && !ack_sync;
    assign busy      = (state != IDLE);

`ifdef CDC_XFER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] phase_cnt;
    logic             to_err;

    // Counts cycles spent in the current handshake phase without the awaited ack level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_cnt <= '0;
        end else if (state == IDLE || state == ERR || (state == REQ_HI && ack_sync)) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + 1'b1;
        end
    end

    assign to_err = (phase_cnt == CNT_W'(TIMEOUT_CYC - 1)) &&
                    ((state == REQ_HI && !ack_sync) || (state == REQ_LO && ack_sync));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_err <= 1'b0;
        end else if (to_err) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    // NOTE: non-blocking assignments keep every register reading pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            req_out      <= 1'b0;
            data_out     <= '0;
            src_gnt      <= '0;
            src_done     <= '0;
            last_granted <= IDX_W'(NUM_REQ - 1);
            cur_idx      <= '0;
        end else begin
            src_gnt  <= '0;
            src_done <= '0;
            case (state)
                IDLE: begin
                    if (grant_now) begin
                        state    <= REQ_HI;
                        req_out  <= 1'b1;
                        data_out <= arb_data;
                        src_gnt  <= arb_gnt;
                        cur_idx  <= arb_idx;
                    end
                end
                REQ_HI: begin
                    if (ack_sync) begin
                        req_out <= 1'b0;
                        state   <= REQ_LO;
                    end
                end
                REQ_LO: begin
                    if (!ack_sync) begin
                        state        <= IDLE;
                        src_done     <= NUM_REQ'(1) << cur_idx;
                        last_granted <= cur_idx;
                    end
                end
`ifdef CDC_XFER_TIMEOUT_EN
                ERR: begin
                    if (!ack_sync) begin
                        state        <= IDLE;
                        last_granted <= cur_idx;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
`ifdef CDC_XFER_TIMEOUT_EN
            // Only fires when the phase branch above made no move, so it never conflicts.
            if (to_err) begin
                state   <= ERR;
                req_out <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Self-checking bench for cdc_xfer_arbiter: directed scenarios plus randomized traffic
// scored cycle-by-cycle against a transaction-level handshake model.
`timescale 1ns/1ps
module tb_cdc_xfer_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 16;
    localparam int MAX_WAIT    = 300;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic [NUM_REQ-1:0]        src_req = '0;
    logic [NUM_REQ*DATA_W-1:0] src_data = '0;
    logic                      ack_sync = 1'b0;
    logic [NUM_REQ-1:0]        src_gnt;
    logic [NUM_REQ-1:0]        src_done;
    logic                      req_out;
    logic [DATA_W-1:0]         data_out;
    logic                      busy;
    logic                      timeout_err;

    cdc_xfer_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .src_req     (src_req),
        .src_data    (src_data),
        .src_gnt     (src_gnt),
        .src_done    (src_done),
        .req_out     (req_out),
        .data_out    (data_out),
        .ack_sync    (ack_sync),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Transaction-level model of the shared channel.
    bit                        m_in_xfer;
    bit                        m_req_out;
    bit                        m_err;
    bit                        m_timeout;
    int                        m_owner;
    int                        m_last = NUM_REQ - 1;
    int                        m_age;
    logic [DATA_W-1:0]         m_data;
    logic [NUM_REQ-1:0]        m_gnt;
    logic [NUM_REQ-1:0]        m_done;
    logic [NUM_REQ-1:0]        s_req;
    logic [NUM_REQ*DATA_W-1:0] s_data;
    logic                      s_ack;
    int                        gnt_log[$];
    int                        gnt_cnt[NUM_REQ];
    int                        done_cnt[NUM_REQ];

    task automatic phase_stall();
`ifdef CDC_XFER_TIMEOUT_EN
        m_age++;
        if (m_age == TIMEOUT_CYC) begin
            m_err     = 1'b1;
            m_req_out = 1'b0;
            m_timeout = 1'b1;
        end
`endif
    endtask

    always @(posedge clk) begin
        s_req  = src_req;
        s_data = src_data;
        s_ack  = ack_sync;
        m_gnt  = '0;
        m_done = '0;
        if (!reset) begin
            m_in_xfer = 1'b0;
            m_req_out = 1'b0;
            m_err     = 1'b0;
            m_timeout = 1'b0;
            m_last    = NUM_REQ - 1;
            m_data    = '0;
        end else if (!m_in_xfer) begin
            if (s_req != '0 && !s_ack) begin
                m_owner          = rr_pick(s_req, m_last);
                m_in_xfer        = 1'b1;
                m_req_out        = 1'b1;
                m_age            = 0;
                m_data           = s_data[m_owner*DATA_W +: DATA_W];
                m_gnt[m_owner]   = 1'b1;
            end
        end else if (m_err) begin
            if (!s_ack) begin
                m_in_xfer = 1'b0;
                m_err     = 1'b0;
                m_last    = m_owner;
            end
        end else if (m_req_out) begin
            if (s_ack) begin
                m_req_out = 1'b0;
                m_age     = 0;
            end else begin
                phase_stall();
            end
        end else begin
            if (!s_ack) begin
                m_in_xfer       = 1'b0;
                m_done[m_owner] = 1'b1;
                m_last          = m_owner;
            end else begin
                phase_stall();
            end
        end
        #1;
        check("sb_gnt", src_gnt, m_gnt);
        check("sb_done", src_done, m_done);
        check("sb_req_out", req_out, m_req_out);
        check("sb_data_out", data_out, m_data);
        check("sb_busy", busy, m_in_xfer);
        check("sb_timeout_err", timeout_err, m_timeout);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_gnt[i]) begin
                gnt_log.push_back(i);
                gnt_cnt[i]++;
            end
            if (src_done[i]) done_cnt[i]++;
        end
    end

    // Stimulus side: a destination responder mirrors req_out onto ack after a random delay.
    bit auto_ack = 1'b0;
    int ack_wait = 0;

    task automatic tick();
        @(negedge clk);
        if (auto_ack && ack_sync != req_out) begin
            if (ack_wait == 0) begin
                ack_sync = req_out;
                ack_wait = $urandom_range(0, 3);
            end else begin
                ack_wait--;
            end
        end
    endtask

    task automatic wait_req_out(input logic lvl, input string tag);
        int n = 0;
        while (req_out !== lvl && n < MAX_WAIT) begin
            tick();
            n++;
        end
        check(tag, req_out, lvl);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < MAX_WAIT) begin
            tick();
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_req_out", req_out, 1'b0);
        check("rst_data_out", data_out, '0);
        check("rst_gnt", src_gnt, '0);
        check("rst_done", src_done, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        int g0;
        int d0;
        int t;

        tick();
        tick();
        reset = 1'b1;

        // Single requester with fixed 3-cycle ack latency in both phases.
        do_reset();
        auto_ack = 1'b0;
        ack_sync = 1'b0;
        src_data = '0;
        src_data[2*DATA_W +: DATA_W] = 8'h5A;
        src_req  = 4'b0100;
        g0 = gnt_cnt[2];
        d0 = done_cnt[2];
        wait_req_out(1'b1, "single_req_hi");
        src_req = '0;
        repeat (3) tick();
        ack_sync = 1'b1;
        wait_req_out(1'b0, "single_req_lo");
        check("single_data_mid", data_out, 8'h5A);
        repeat (3) tick();
        ack_sync = 1'b0;
        repeat (4) tick();
        check("single_gnt_count", gnt_cnt[2] - g0, 1);
        check("single_done_count", done_cnt[2] - d0, 1);
        check("single_data_hold", data_out, 8'h5A);

        // All four requesting continuously: strict rotation from index 0.
        do_reset();
        auto_ack = 1'b1;
        src_req  = 4'hF;
        src_data = {$urandom};
        base = gnt_log.size();
        n = 0;
        while (gnt_log.size() < base + 5 && n < MAX_WAIT) begin
            tick();
            n++;
        end
        src_req = '0;
        check("rr_grants_seen", (gnt_log.size() >= base + 5), 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (gnt_log.size() > base + i) check("rr_order", gnt_log[base + i], i % NUM_REQ);
        end
        wait_idle("rr_idle");

        // Ack held high while idle blocks the grant until it drops.
        do_reset();
        auto_ack = 1'b0;
        ack_sync = 1'b1;
        src_req  = 4'b0001;
        base = gnt_log.size();
        repeat (6) tick();
        check("stale_ack_no_grant", gnt_log.size() - base, 0);
        check("stale_ack_busy", busy, 1'b0);
        ack_sync = 1'b0;
        wait_req_out(1'b1, "stale_ack_release");
        check("stale_ack_winner", gnt_log[$], 0);
        src_req  = '0;
        auto_ack = 1'b1;
        wait_idle("stale_ack_idle");

        // Reset in REQ_HI aborts the transfer and restarts the rotation at index 0.
        do_reset();
        auto_ack = 1'b1;
        src_req  = 4'b0001;
        d0 = done_cnt[0];
        n = 0;
        while (done_cnt[0] == d0 && n < MAX_WAIT) begin
            tick();
            n++;
        end
        src_req = '0;
        wait_idle("abort_pre_idle");
        auto_ack = 1'b0;
        ack_sync = 1'b0;
        src_req  = 4'b0011;
        wait_req_out(1'b1, "abort_req_hi");
        check("abort_first_winner", gnt_log[$], 1);
        d0 = done_cnt[1];
        @(negedge clk);
        #2;
        reset    = 1'b0;
        ack_sync = 1'b1;
        #1;
        check("abort_req_out_async", req_out, 1'b0);
        check("abort_busy_async", busy, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        base = gnt_log.size();
        repeat (3) tick();
        check("abort_stale_ack_block", gnt_log.size() - base, 0);
        ack_sync = 1'b0;
        wait_req_out(1'b1, "abort_regrant");
        check("abort_next_winner", gnt_log[$], 0);
        check("abort_no_done", done_cnt[1] - d0, 0);
        src_req  = '0;
        auto_ack = 1'b1;
        wait_idle("abort_idle");

        // Randomized traffic with withdrawals and variable ack latency.
        auto_ack = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) src_req = NUM_REQ'($urandom_range(0, 15));
            src_data = {$urandom};
            tick();
        end
        src_req = '0;
        wait_idle("rand_idle");

`ifdef CDC_XFER_TIMEOUT_EN
        // Stuck-low ack: watchdog fires after TIMEOUT_CYC cycles in REQ_HI.
        do_reset();
        auto_ack = 1'b0;
        ack_sync = 1'b0;
        src_req  = 4'b0001;
        wait_req_out(1'b1, "to_req_hi");
        src_req = 4'b0011;
        t = 0;
        while (timeout_err !== 1'b1 && t < MAX_WAIT) begin
            tick();
            t++;
        end
        check("to_cycles", t, TIMEOUT_CYC);
        check("to_req_out", req_out, 1'b0);
        check("to_busy_err", busy, 1'b1);
        wait_req_out(1'b1, "to_regrant");
        check("to_next_winner", gnt_log[$], 1);
        check("to_sticky", timeout_err, 1'b1);
        src_req = '0;
        do_reset();
`else
        t = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
